// File: rtl/playfield_engine.sv
// playfield_engine
//   Game-state generator for a 16x16 LED matrix with two-bit intensity.
//   It holds the settled playfield and one falling 2x2 block. It applies
//   gravity and player moves, locks the block in place and clears full rows.
//   The scanner reads pixels through a combinational read port.
//
// Parameters
//   DROP_DIV  clk cycles per gravity step (must be >= 2)
//   SPAWN_X   column of the block's left cells at spawn (0..14)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_left   one-cycle pulse: move the block one column left
//   btn_right  one-cycle pulse: move the block one column right
//   btn_down   one-cycle pulse: soft drop (same as a gravity step)
//   restart    one-cycle pulse: clear the field and start a new game
//   rd_row     scanner read row (0 = top)
//   rd_col     scanner read column (0 = left)
//   rd_pix     intensity at (rd_row, rd_col): 0 empty, 2 settled, 3 falling
//   lines      count of cleared rows, modulo 256
//   game_over  high while the game is over
//   busy       high while locking the block or clearing rows
module playfield_engine #(
  parameter int unsigned DROP_DIV = 8_000_000,
  parameter int unsigned SPAWN_X  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       restart,
  input  logic [3:0] rd_row,
  input  logic [3:0] rd_col,
  output logic [1:0] rd_pix,
  output logic [7:0] lines,
  output logic       game_over,
  output logic       busy
);

  localparam int unsigned       CNT_W     = $clog2(DROP_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DROP_DIV - 1);
  localparam logic [3:0]        SPAWN_COL = 4'(SPAWN_X);

  typedef enum logic [2:0] {
    ST_SPAWN    = 3'd0,
    ST_FALL     = 3'd1,
    ST_LOCK     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  // field_q[row][col]: 1 = occupied
  logic [15:0]      field_q [16];
  logic [15:0]      field_d [16];
  state_t           state_q, state_d;
  logic [3:0]       bx_q, bx_d;
  logic [3:0]       by_q, by_d;
  logic [3:0]       r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lines_q, lines_d;

  logic [3:0] by_p1, by_p2, bx_p1, bx_p2, bx_m1;
  logic       spawn_blocked, step, land_blocked, left_ok, right_ok, row_full;

  // The bx/by offsets may wrap at the edges. Each use is guarded by a
  // boundary test on bx/by, so the wrapped index is never acted on.
  assign by_p1 = by_q + 4'd1;
  assign by_p2 = by_q + 4'd2;
  assign bx_p1 = bx_q + 4'd1;
  assign bx_p2 = bx_q + 4'd2;
  assign bx_m1 = bx_q - 4'd1;

  assign spawn_blocked = field_q[0][SPAWN_COL] | field_q[0][SPAWN_COL + 4'd1] |
                         field_q[1][SPAWN_COL] | field_q[1][SPAWN_COL + 4'd1];
  assign step          = btn_down | (cnt_q == CNT_MAX);
  assign land_blocked  = (by_q == 4'd14) | field_q[by_p2][bx_q] | field_q[by_p2][bx_p1];
  assign left_ok       = (bx_q != 4'd0) & ~field_q[by_q][bx_m1] & ~field_q[by_p1][bx_m1];
  assign right_ok      = (bx_q < 4'd14) & ~field_q[by_q][bx_p2] & ~field_q[by_p1][bx_p2];
  assign row_full      = &field_q[r_q];

  always_comb begin
    field_d = field_q;
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;

    if (restart) begin
      for (int unsigned k = 0; k < 16; k++) begin
        field_d[4'(k)] = '0;
      end
      lines_d = '0;
      r_d     = 4'd15;
      state_d = ST_SPAWN;
    end else begin
      case (state_q)
        ST_SPAWN: begin
          bx_d    = SPAWN_COL;
          by_d    = '0;
          cnt_d   = '0;
          state_d = spawn_blocked ? ST_GAMEOVER : ST_FALL;
        end

        ST_FALL: begin
          cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
          // A step wins over any move that arrives in the same cycle.
          if (step) begin
            if (land_blocked) begin
              state_d = ST_LOCK;
            end else begin
              by_d = by_p1;
            end
          end else if (btn_left && !btn_right && left_ok) begin
            bx_d = bx_m1;
          end else if (btn_right && !btn_left && right_ok) begin
            bx_d = bx_p1;
          end
        end

        ST_LOCK: begin
          field_d[by_q][bx_q]   = 1'b1;
          field_d[by_q][bx_p1]  = 1'b1;
          field_d[by_p1][bx_q]  = 1'b1;
          field_d[by_p1][bx_p1] = 1'b1;
          r_d     = 4'd15;
          state_d = ST_CLEAR;
        end

        ST_CLEAR: begin
          if (row_full) begin
            // Collapse rows 0..r down by one. r is held, so the row that
            // just moved into r is checked on the next cycle.
            field_d[0] = '0;
            for (int unsigned k = 1; k < 16; k++) begin
              if (4'(k) <= r_q) begin
                field_d[4'(k)] = field_q[4'(k - 1)];
              end
            end
            lines_d = lines_q + 8'd1;
          end else if (r_q == 4'd0) begin
            state_d = ST_SPAWN;
          end else begin
            r_d = r_q - 4'd1;
          end
        end

        ST_GAMEOVER: begin
        end

        default: state_d = ST_SPAWN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 16; k++) begin
        field_q[4'(k)] <= '0;
      end
      state_q <= ST_SPAWN;
      bx_q    <= SPAWN_COL;
      by_q    <= '0;
      r_q     <= 4'd15;
      cnt_q   <= '0;
      lines_q <= '0;
    end else begin
      field_q <= field_d;
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
    end
  end

  logic cover_row, cover_col;
  assign cover_row = (rd_row == by_q) | (rd_row == by_p1);
  assign cover_col = (rd_col == bx_q) | (rd_col == bx_p1);

  always_comb begin
    if ((state_q == ST_FALL) && cover_row && cover_col) begin
      rd_pix = 2'd3;
    end else if (field_q[rd_row][rd_col]) begin
      rd_pix = 2'd2;
    end else begin
      rd_pix = 2'd0;
    end
  end

  assign lines     = lines_q;
  assign game_over = (state_q == ST_GAMEOVER);
  assign busy      = (state_q == ST_LOCK) || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_playfield_engine.sv
module tb_playfield_engine;

  localparam int DIV = 40;
  localparam int SX  = 7;

  localparam int PH_SPAWN = 10;
  localparam int PH_FALL  = 11;
  localparam int PH_LOCK  = 12;
  localparam int PH_CLEAR = 13;
  localparam int PH_GO    = 14;

  logic       clk, rst_n;
  logic       btn_left, btn_right, btn_down, restart;
  logic [3:0] rd_row, rd_col;
  logic [1:0] rd_pix;
  logic [7:0] lines;
  logic       game_over, busy;

  int checks = 0;
  int errors = 0;

  playfield_engine #(.DROP_DIV(DIV), .SPAWN_X(SX)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down), .restart(restart),
    .rd_row(rd_row), .rd_col(rd_col), .rd_pix(rd_pix),
    .lines(lines), .game_over(game_over), .busy(busy)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  // Reference model: the game rules applied to a plain 2-D grid
  bit m_f [16][16];
  int m_ph, m_bx, m_by, m_cnt, m_r, m_lines;

  task model_reset();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) m_f[i][j] = 1'b0;
    m_ph = PH_SPAWN; m_bx = SX; m_by = 0; m_cnt = 0; m_r = 15; m_lines = 0;
  endtask

  function automatic int exp_pix(int r, int c);
    if (m_ph == PH_FALL && r >= m_by && r <= m_by + 1 && c >= m_bx && c <= m_bx + 1) return 3;
    return m_f[r][c] ? 2 : 0;
  endfunction

  task model_clock(input bit l, input bit rt, input bit d, input bit rs);
    bit st, full;
    if (rs) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) m_f[i][j] = 1'b0;
      m_lines = 0;
      m_ph = PH_SPAWN;
      return;
    end
    case (m_ph)
      PH_SPAWN: begin
        m_bx = SX; m_by = 0; m_cnt = 0;
        if (m_f[0][SX] || m_f[0][SX+1] || m_f[1][SX] || m_f[1][SX+1]) m_ph = PH_GO;
        else m_ph = PH_FALL;
      end
      PH_FALL: begin
        st = d || (m_cnt == DIV - 1);
        m_cnt = (m_cnt + 1) % DIV;
        if (st) begin
          if (m_by == 14 || m_f[m_by+2][m_bx] || m_f[m_by+2][m_bx+1]) m_ph = PH_LOCK;
          else m_by++;
        end else if (l && !rt) begin
          if (m_bx > 0 && !m_f[m_by][m_bx-1] && !m_f[m_by+1][m_bx-1]) m_bx--;
        end else if (rt && !l) begin
          if (m_bx < 14 && !m_f[m_by][m_bx+2] && !m_f[m_by+1][m_bx+2]) m_bx++;
        end
      end
      PH_LOCK: begin
        m_f[m_by][m_bx] = 1'b1;   m_f[m_by][m_bx+1] = 1'b1;
        m_f[m_by+1][m_bx] = 1'b1; m_f[m_by+1][m_bx+1] = 1'b1;
        m_r = 15;
        m_ph = PH_CLEAR;
      end
      PH_CLEAR: begin
        full = 1'b1;
        for (int j = 0; j < 16; j++) if (!m_f[m_r][j]) full = 1'b0;
        if (full) begin
          for (int k = m_r; k >= 1; k--)
            for (int j = 0; j < 16; j++) m_f[k][j] = m_f[k-1][j];
          for (int j = 0; j < 16; j++) m_f[0][j] = 1'b0;
          m_lines = (m_lines + 1) % 256;
        end else if (m_r == 0) begin
          m_ph = PH_SPAWN;
        end else begin
          m_r--;
        end
      end
      default: ;
    endcase
  endtask

  task check_all();
    int bad, fr, fc, fg, fe;
    logic exp_go, exp_busy;
    bad = 0; fr = 0; fc = 0; fg = 0; fe = 0;
    for (int rr = 0; rr < 16; rr++) begin
      for (int cc = 0; cc < 16; cc++) begin
        rd_row = 4'(rr); rd_col = 4'(cc);
        #1;
        if (rd_pix !== 2'(exp_pix(rr, cc))) begin
          if (bad == 0) begin fr = rr; fc = cc; fg = int'(rd_pix); fe = exp_pix(rr, cc); end
          bad++;
        end
      end
    end
    checks++;
    assert (bad == 0) else begin
      errors++;
      $error("FAIL frame: %0d pixels differ, first (%0d,%0d) got %0d want %0d", bad, fr, fc, fg, fe);
    end
    exp_go   = (m_ph == PH_GO);
    exp_busy = (m_ph == PH_LOCK) || (m_ph == PH_CLEAR);
    checks++;
    assert (game_over === exp_go) else begin
      errors++; $error("FAIL game_over: got %b want %b", game_over, exp_go);
    end
    checks++;
    assert (busy === exp_busy) else begin
      errors++; $error("FAIL busy: got %b want %b", busy, exp_busy);
    end
    checks++;
    assert (lines === 8'(m_lines)) else begin
      errors++; $error("FAIL lines: got %0d want %0d", lines, m_lines);
    end
  endtask

  task automatic tick(input bit l, input bit rt, input bit d, input bit rs);
    btn_left = l; btn_right = rt; btn_down = d; restart = rs;
    @(posedge clk);
    model_clock(l, rt, d, rs);
    #1;
    btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b0; restart = 1'b0;
    check_all();
  endtask

  task automatic expect_pix(input string tag, input int r, input int c, input logic [1:0] want);
    rd_row = 4'(r); rd_col = 4'(c);
    #1;
    checks++;
    assert (rd_pix === want) else begin
      errors++; $error("FAIL %s: pixel(%0d,%0d) got %0d want %0d", tag, r, c, rd_pix, want);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++; $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Steer the current block to column tx, drop it, and wait for the next
  // block (or game over). Returns the number of cycles busy was seen high.
  task automatic drop_at(input int tx, output int bc);
    int g;
    g = 0;
    while (m_ph != PH_FALL && m_ph != PH_GO && g < 60) begin tick(0, 0, 0, 0); g++; end
    g = 0;
    while (m_ph == PH_FALL && m_bx != tx && g < 20) begin
      if (m_bx > tx) tick(1, 0, 0, 0); else tick(0, 1, 0, 0);
      g++;
    end
    g = 0;
    while (m_ph == PH_FALL && g < 20) begin tick(0, 0, 1, 0); g++; end
    bc = busy ? 1 : 0;
    g = 0;
    while (m_ph != PH_FALL && m_ph != PH_GO && g < 60) begin
      tick(0, 0, 0, 0);
      if (busy === 1'b1) bc++;
      g++;
    end
    checks++;
    assert (g < 60) else begin
      errors++; $error("FAIL drop_timeout: waited %0d cycles, limit 60", g);
    end
  endtask

  initial begin
    int bc, g;
    btn_left = 0; btn_right = 0; btn_down = 0; restart = 0;
    rd_row = 0; rd_col = 0;
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    model_reset();
    #5 check_all();
    #30 rst_n = 1'b1;

    // First edge: SPAWN -> FALL, block at (0,7)
    tick(0, 0, 0, 0);
    expect_pix("spawn_tl", 0, 7, 2'd3);
    expect_pix("spawn_br", 1, 8, 2'd3);
    expect_pix("spawn_below", 2, 7, 2'd0);
    expect_pix("spawn_left", 0, 6, 2'd0);

    // Eight left pulses, one idle cycle apart: stops at column 0
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
    end
    expect_pix("left_edge", 0, 0, 2'd3);
    expect_pix("left_edge_r", 0, 2, 2'd0);

    // 14 soft drops to the floor, 15th locks; LOCK + 16 CLEAR = 17 busy
    for (int i = 0; i < 14; i++) tick(0, 0, 1, 0);
    expect_pix("floor_block", 15, 0, 2'd3);
    expect_pix("floor_above", 13, 0, 2'd0);
    tick(0, 0, 1, 0);
    bc = busy ? 1 : 0;
    g = 0;
    while (m_ph != PH_FALL && g < 60) begin
      tick(0, 0, 0, 0);
      if (busy === 1'b1) bc++;
      g++;
    end
    expect_int("busy_lock", bc, 17);
    expect_pix("settled_a", 14, 0, 2'd2);
    expect_pix("settled_b", 15, 1, 2'd2);
    expect_pix("respawn", 0, 7, 2'd3);

    // Fill columns 0..13 of rows 14-15, then close them with a block at 14
    for (int t = 2; t <= 12; t += 2) drop_at(t, bc);
    drop_at(14, bc);
    expect_int("busy_clear2", bc, 19);
    expect_int("lines_two", int'(lines), 2);
    expect_pix("cleared_a", 15, 0, 2'd0);
    expect_pix("cleared_b", 14, 13, 2'd0);

    // Stack at the spawn column until the spawn is blocked
    g = 0;
    while (m_ph != PH_GO && g < 12) begin drop_at(SX, bc); g++; end
    expect_int("game_over_hi", int'(game_over), 1);
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    expect_pix("frozen", 0, 7, 2'd2);
    tick(0, 0, 0, 1);
    expect_int("restart_lines", int'(lines), 0);
    expect_int("restart_go", int'(game_over), 0);
    expect_pix("restart_empty", 15, 7, 2'd0);
    tick(0, 0, 0, 0);
    expect_pix("restart_spawn", 0, 7, 2'd3);

    // Left, right and down together: only the drop applies
    tick(1, 1, 1, 0);
    expect_pix("combo_new", 2, 7, 2'd3);
    expect_pix("combo_old", 0, 7, 2'd0);
    expect_pix("combo_l", 1, 6, 2'd0);
    expect_pix("combo_r", 1, 9, 2'd0);

    // Random play checked against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 299) == 0);
    end

    // Asynchronous reset during CLEAR, with no clock edge afterwards
    tick(0, 0, 0, 1);
    g = 0;
    while (m_ph != PH_FALL && g < 10) begin tick(0, 0, 0, 0); g++; end
    g = 0;
    while (m_ph == PH_FALL && g < 20) begin tick(0, 0, 1, 0); g++; end
    tick(0, 0, 0, 0);
    expect_int("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    expect_int("async_busy", int'(busy), 0);
    expect_int("async_go", int'(game_over), 0);
    check_all();
    rst_n = 1'b1;
    tick(0, 0, 0, 0);
    expect_pix("post_reset_spawn", 0, 7, 2'd3);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
